sam_video_addr: RTL and testbench
=================================

// Module: sam_video_addr
// PURPOSE
//  Memory-side counterpart of the VDG timing outputs: consumes DA0, HSn, FSn from the VDG and
//  produces the video RAM byte address the VDG's Data bus is fed from (SAM-style counter).
//  Sits between the VDG and the video RAM arbiter; one address per DA0 falling edge, with
//  per-mode row repeat so the same line of bytes is re-read for 12/3/2/1 scanlines.
// PARAMETERS
//  SYNC_STAGES     2   flops in each input synchroniser (>=1)
//  BYTES_PER_LINE  32  max address advances per scanline; further DA0 edges in the line ignored
// PORTS
//  Clk         in   1   system clock, all logic rising-edge
//  Rstn        in   1   asynchronous active-low reset
//  DA0         in   1   VDG display address strobe; falling edge = next byte
//  HSn         in   1   VDG horizontal sync, active low; falling edge = end of scanline
//  FSn         in   1   VDG field sync, active low; falling edge = end of field
//  VMode       in   3   display mode V2..V0, selects row repeat
//  VBase       in   7   display base F6..F0; frame start address = {VBase, 9'b0}
//  VAddr       out  16  current video byte address
//  ByteStrobe  out  1   1-cycle pulse each time VAddr takes a new value from a DA0 advance
//  RowCount    out  4   scanline index within current repeated row, 0..repeat-1
//  FrameStart  out  1   1-cycle pulse when VAddr is reloaded from VBase
// BEHAVIOUR
//  Reset: VAddr=0, LineStart=0, ByteCnt=0, RowCount=0, ByteStrobe=0, FrameStart=0, sync flops=1.
//  Inputs pass SYNC_STAGES flops then a falling-edge detector; each event acts on the Clk edge
//   SYNC_STAGES+1 cycles after the first Clk edge that samples the new low level.
//  Row repeat R by VMode: 0->12, 1->3, 2->3, 3->2, 4->2, 5->1, 6->1, 7->1.
//  FSn event: VAddr<=LineStart<={VBase,9'b0}; RowCount<=0; ByteCnt<=0; FrameStart=1 one cycle.
//   VBase sampled only here; changes at other times have no effect until next field.
//  DA0 event: if ByteCnt<BYTES_PER_LINE: VAddr<=VAddr+1 (16-bit wrap FFFF->0000), ByteCnt++,
//   ByteStrobe=1 one cycle. Else no change, no strobe.
//  HSn event: ByteCnt<=0. If RowCount>=R-1: RowCount<=0, LineStart<=VAddr (advance to next row).
//   Else RowCount++, VAddr<=LineStart (rewind, re-read same bytes).
//  VMode change: takes effect at next HSn event; RowCount>=new R-1 treated as last row (no hang).
//  Simultaneous events in one cycle: FSn > HSn > DA0; lower-priority events that cycle dropped.
//  Reset mid-frame: all state to reset values immediately; counting resumes from 0 (not VBase)
//   until first FSn event.
//  ByteStrobe and FrameStart never asserted in the same cycle.
// STRUCTURE
//  Package sam_video_pkg: mode encodings, ROW_REPEAT constant table/function (VMode->R),
//   VADDR_W=16, BASE_W=7, BASE_SHIFT=9.
//  Sub-module sam_edge_sync: SYNC_STAGES synchroniser + registered falling-edge pulse,
//   instantiated three times (DA0, HSn, FSn). Counters and priority logic live in the top.
// TESTING
//  Reset: Rstn low with inputs toggling -> VAddr=0000, RowCount=0, no strobes; release clean.
//  Frame load: VBase=7'h02, pulse FSn low -> VAddr=0400 after SYNC_STAGES+1 cycles, FrameStart=1.
//  Alpha repeat: VMode=0, VBase=02, 32 DA0 + 1 HSn per line x 24 lines -> lines 0-11 read
//   0400-041F, lines 12-23 read 0420-043F; RowCount 0..11 then 0.
//  Overrun/wrap: BYTES_PER_LINE=32, 40 DA0 edges -> VAddr advances 32 only, 32 strobes;
//   VBase=7'h7F, VMode=5, 512 bytes -> VAddr wraps FFFF->0000.
//  Collision: FSn and HSn falls in same sync cycle -> FSn reload only, RowCount=0;
//   DA0 with HSn same cycle -> no increment, no ByteStrobe.
//  Mode switch: VMode 0->5 at RowCount=7 -> next HSn advances row, RowCount=0 thereafter.

Source files
------------

// File: rtl/sam_video_pkg.sv
// Shared widths, VDG mode encodings and the mode-to-row-repeat table for the SAM video counter.
package sam_video_pkg;

  localparam int unsigned VADDR_W    = 16;
  localparam int unsigned BASE_W     = 7;
  localparam int unsigned BASE_SHIFT = 9;
  localparam int unsigned MODE_W     = 3;
  localparam int unsigned ROW_W      = 4;

  typedef enum logic [MODE_W-1:0] {
    VM_ALPHA = 3'd0,
    VM_G1C   = 3'd1,
    VM_G1R   = 3'd2,
    VM_G2C   = 3'd3,
    VM_G2R   = 3'd4,
    VM_G3C   = 3'd5,
    VM_G3R   = 3'd6,
    VM_G6    = 3'd7
  } vmode_e;

  // One falling-edge event per VDG timing input, already synchronised.
  typedef struct packed {
    logic fs;
    logic hs;
    logic da;
  } vdg_evt_t;

  // Number of scanlines that re-read the same row of bytes.
  function automatic logic [ROW_W-1:0] row_repeat(input logic [MODE_W-1:0] mode);
    logic [ROW_W-1:0] rep;
    case (vmode_e'(mode))
      VM_ALPHA:        rep = ROW_W'(12);
      VM_G1C, VM_G1R:  rep = ROW_W'(3);
      VM_G2C, VM_G2R:  rep = ROW_W'(2);
      default:         rep = ROW_W'(1);
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/sam_edge_sync.sv
// Multi-flop synchroniser followed by a registered one-cycle falling-edge pulse.
module sam_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_fall;
  logic                   w_fall;

  assign w_fall = r_prev & ~r_sync[SYNC_STAGES-1];
  assign o_fall = r_fall;

  // Idle level of every VDG strobe is high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
      r_fall <= w_fall;
    end
  end

endmodule

// File: rtl/sam_video_addr.sv
// SAM-style video address counter: byte advance on DA0, row repeat/advance on HSn, reload on FSn.
module sam_video_addr
  import sam_video_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned BYTES_PER_LINE = 32
) (
  input  logic               Clk,
  input  logic               Rstn,
  input  logic               DA0,
  input  logic               HSn,
  input  logic               FSn,
  input  logic [MODE_W-1:0]  VMode,
  input  logic [BASE_W-1:0]  VBase,
  output logic [VADDR_W-1:0] VAddr,
  output logic               ByteStrobe,
  output logic [ROW_W-1:0]   RowCount,
  output logic               FrameStart
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_LINE + 1);

  vdg_evt_t w_evt;

  logic [VADDR_W-1:0] r_vaddr,      w_vaddr;
  logic [VADDR_W-1:0] r_line_start, w_line_start;
  logic [CNT_W-1:0]   r_byte_cnt,   w_byte_cnt;
  logic [ROW_W-1:0]   r_row_count,  w_row_count;
  logic               r_byte_strobe, w_byte_strobe;
  logic               r_frame_start, w_frame_start;
  logic               w_last_row;
  logic               w_room;

  sam_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fs (
    .i_clk(Clk), .i_rst_n(Rstn), .i_d(FSn), .o_fall(w_evt.fs)
  );
  sam_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_hs (
    .i_clk(Clk), .i_rst_n(Rstn), .i_d(HSn), .o_fall(w_evt.hs)
  );
  sam_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_da (
    .i_clk(Clk), .i_rst_n(Rstn), .i_d(DA0), .o_fall(w_evt.da)
  );

  // ">=" rather than "==" so a mode switch to a shorter repeat can never strand the row counter.
  assign w_last_row = (r_row_count >= (row_repeat(VMode) - ROW_W'(1)));
  assign w_room     = (r_byte_cnt < CNT_W'(BYTES_PER_LINE));

  // Event priority FSn > HSn > DA0; a lower-priority event in the same cycle is dropped.
  always_comb begin
    w_vaddr       = r_vaddr;
    w_line_start  = r_line_start;
    w_byte_cnt    = r_byte_cnt;
    w_row_count   = r_row_count;
    w_byte_strobe = 1'b0;
    w_frame_start = 1'b0;
    if (w_evt.fs) begin
      w_line_start  = {VBase, {BASE_SHIFT{1'b0}}};
      w_vaddr       = {VBase, {BASE_SHIFT{1'b0}}};
      w_row_count   = '0;
      w_byte_cnt    = '0;
      w_frame_start = 1'b1;
    end else if (w_evt.hs) begin
      w_byte_cnt = '0;
      if (w_last_row) begin
        w_row_count  = '0;
        w_line_start = r_vaddr;
      end else begin
        w_row_count = r_row_count + ROW_W'(1);
        w_vaddr     = r_line_start;
      end
    end else if (w_evt.da && w_room) begin
      w_vaddr       = r_vaddr + VADDR_W'(1);
      w_byte_cnt    = r_byte_cnt + CNT_W'(1);
      w_byte_strobe = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      r_vaddr       <= '0;
      r_line_start  <= '0;
      r_byte_cnt    <= '0;
      r_row_count   <= '0;
      r_byte_strobe <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_vaddr       <= w_vaddr;
      r_line_start  <= w_line_start;
      r_byte_cnt    <= w_byte_cnt;
      r_row_count   <= w_row_count;
      r_byte_strobe <= w_byte_strobe;
      r_frame_start <= w_frame_start;
    end
  end

  assign VAddr      = r_vaddr;
  assign ByteStrobe = r_byte_strobe;
  assign RowCount   = r_row_count;
  assign FrameStart = r_frame_start;

endmodule

// File: tb/tb_sam_video_addr.sv
// Directed and randomized checks of sam_video_addr against an event-level model of the counter rules.
module tb_sam_video_addr;

  logic        Clk = 1'b0;
  logic        Rstn;
  logic        DA0, HSn, FSn;
  logic [2:0]  VMode;
  logic [6:0]  VBase;
  logic [15:0] VAddr;
  logic        ByteStrobe;
  logic [3:0]  RowCount;
  logic        FrameStart;

  sam_video_addr dut (
    .Clk(Clk), .Rstn(Rstn), .DA0(DA0), .HSn(HSn), .FSn(FSn),
    .VMode(VMode), .VBase(VBase), .VAddr(VAddr), .ByteStrobe(ByteStrobe),
    .RowCount(RowCount), .FrameStart(FrameStart)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_bs  = 0;
  int n_fsp = 0;
  bit both_seen = 1'b0;

  int m_vaddr, m_line, m_cnt, m_row;
  int m_bs  = 0;
  int m_fsc = 0;
  int rep [8] = '{12, 3, 3, 2, 2, 1, 1, 1};

  // Count strobe cycles observed on the outputs.
  always @(posedge Clk) begin
    #1;
    if (ByteStrobe === 1'b1) n_bs++;
    if (FrameStart === 1'b1) n_fsp++;
    if (ByteStrobe === 1'b1 && FrameStart === 1'b1) both_seen = 1'b1;
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vaddr = 0; m_line = 0; m_cnt = 0; m_row = 0;
  endtask

  task automatic model_ev(input bit f, input bit h, input bit d);
    if (f) begin
      m_line  = int'(VBase) * 512;
      m_vaddr = m_line;
      m_row   = 0;
      m_cnt   = 0;
      m_fsc++;
    end else if (h) begin
      m_cnt = 0;
      if (m_row >= rep[VMode] - 1) begin
        m_row  = 0;
        m_line = m_vaddr;
      end else begin
        m_row++;
        m_vaddr = m_line;
      end
    end else if (d && m_cnt < 32) begin
      m_vaddr = (m_vaddr + 1) % 65536;
      m_cnt++;
      m_bs++;
    end
  endtask

  task automatic check_model(input string tag);
    cmp($sformatf("%s_vaddr", tag), 32'(VAddr), m_vaddr);
    cmp($sformatf("%s_row", tag), 32'(RowCount), m_row);
    cmp($sformatf("%s_bs_cnt", tag), n_bs, m_bs);
    cmp($sformatf("%s_fs_cnt", tag), n_fsp, m_fsc);
  endtask

  // Falling edges on the selected inputs in the same cycle; called and returns on a negedge.
  task automatic ev(input bit f, input bit h, input bit d, input string tag);
    if (f) FSn = 1'b0;
    if (h) HSn = 1'b0;
    if (d) DA0 = 1'b0;
    repeat (2) @(negedge Clk);
    FSn = 1'b1; HSn = 1'b1; DA0 = 1'b1;
    repeat (2) @(negedge Clk);
    model_ev(f, h, d);
    check_model(tag);
  endtask

  initial begin
    int bs0;
    Rstn = 1'b0; DA0 = 1'b1; HSn = 1'b1; FSn = 1'b1; VMode = 3'd0; VBase = 7'd0;
    model_reset();

    // Reset held with inputs toggling
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      DA0 = i[0]; HSn = i[1]; FSn = i[2];
      VBase = 7'(i + 1);
    end
    cmp("rst_vaddr", 32'(VAddr), 0);
    cmp("rst_row", 32'(RowCount), 0);
    @(negedge Clk);
    DA0 = 1'b1; HSn = 1'b1; FSn = 1'b1;
    @(negedge Clk);
    Rstn = 1'b1;
    repeat (4) @(negedge Clk);
    cmp("rst_rel_vaddr", 32'(VAddr), 0);
    cmp("rst_rel_bs", n_bs, 0);
    cmp("rst_rel_fs", n_fsp, 0);

    // Counting from 0 before any field sync
    ev(0, 0, 1, "pre_fs");
    cmp("pre_fs_one", 32'(VAddr), 1);

    // Frame load with exact latency
    VBase = 7'h02;
    FSn = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    cmp("fl_early_fs", 32'(FrameStart), 0);
    cmp("fl_early_va", 32'(VAddr), m_vaddr);
    FSn = 1'b1;
    model_ev(1, 0, 0);
    @(posedge Clk);
    #1;
    cmp("fl_fs", 32'(FrameStart), 1);
    cmp("fl_va", 32'(VAddr), 32'h0400);
    cmp("fl_row", 32'(RowCount), 0);
    @(posedge Clk);
    #1;
    cmp("fl_fs_drop", 32'(FrameStart), 0);
    @(negedge Clk);
    check_model("fl");

    // Alphanumeric mode: 12 scanlines per row
    VMode = 3'd0;
    for (int l = 0; l < 24; l++) begin
      cmp("alpha_start", 32'(VAddr), 32'h0400 + (l / 12) * 32);
      cmp("alpha_row", 32'(RowCount), l % 12);
      for (int b = 0; b < 32; b++) ev(0, 0, 1, "alpha_da");
      ev(0, 1, 0, "alpha_hs");
    end
    cmp("alpha_end", 32'(VAddr), 32'h0440);
    cmp("alpha_end_row", 32'(RowCount), 0);

    // Overrun: 40 strobes in one line, only 32 advance
    ev(1, 0, 0, "ovr_fs");
    bs0 = n_bs;
    for (int b = 0; b < 40; b++) ev(0, 0, 1, "ovr_da");
    cmp("ovr_vaddr", 32'(VAddr), 32'h0420);
    cmp("ovr_strobes", n_bs - bs0, 32);
    ev(0, 1, 0, "ovr_hs");

    // Address wrap from the top page
    VBase = 7'h7F; VMode = 3'd5;
    ev(1, 0, 0, "wrap_fs");
    cmp("wrap_base", 32'(VAddr), 32'hFE00);
    for (int l = 0; l < 16; l++) begin
      for (int b = 0; b < 32; b++) ev(0, 0, 1, "wrap_da");
      ev(0, 1, 0, "wrap_hs");
    end
    cmp("wrap_zero", 32'(VAddr), 0);

    // Collisions
    VMode = 3'd0; VBase = 7'h02;
    ev(1, 0, 0, "col_fs");
    ev(0, 1, 0, "col_hs1");
    ev(0, 1, 0, "col_hs2");
    cmp("col_row2", 32'(RowCount), 2);
    VBase = 7'h05;
    ev(1, 1, 0, "col_fshs");
    cmp("col_fshs_va", 32'(VAddr), 32'h0A00);
    cmp("col_fshs_row", 32'(RowCount), 0);
    ev(0, 0, 1, "col_da");
    bs0 = n_bs;
    ev(0, 1, 1, "col_hsda");
    cmp("col_hsda_bs", n_bs - bs0, 0);
    cmp("col_hsda_va", 32'(VAddr), 32'h0A00);

    // Mode switch mid-row
    VMode = 3'd0; VBase = 7'h02;
    ev(1, 0, 0, "ms_fs");
    for (int l = 0; l < 7; l++) begin
      for (int b = 0; b < 4; b++) ev(0, 0, 1, "ms_da");
      ev(0, 1, 0, "ms_hs");
    end
    cmp("ms_row7", 32'(RowCount), 7);
    for (int b = 0; b < 4; b++) ev(0, 0, 1, "ms_da");
    VMode = 3'd5;
    ev(0, 1, 0, "ms_switch");
    cmp("ms_row0", 32'(RowCount), 0);
    cmp("ms_adv", 32'(VAddr), 32'h0404);
    for (int b = 0; b < 2; b++) ev(0, 0, 1, "ms_da2");
    ev(0, 1, 0, "ms_hs2");
    cmp("ms_row_stay", 32'(RowCount), 0);
    cmp("ms_adv2", 32'(VAddr), 32'h0406);

    // Reset mid-frame
    for (int b = 0; b < 3; b++) ev(0, 0, 1, "mr_da");
    Rstn = 1'b0;
    #1;
    cmp("mr_vaddr", 32'(VAddr), 0);
    cmp("mr_row", 32'(RowCount), 0);
    model_reset();
    @(negedge Clk);
    Rstn = 1'b1;
    @(negedge Clk);
    ev(0, 0, 1, "mr_resume");
    cmp("mr_resume_one", 32'(VAddr), 1);

    // Randomized event mix
    for (int k = 0; k < 300; k++) begin
      int r, e;
      bit f, h, d;
      r = int'($urandom_range(0, 99));
      if (r < 5) VMode = 3'($urandom_range(0, 7));
      else if (r < 10) VBase = 7'($urandom);
      e = int'($urandom_range(0, 99));
      f = 1'b0; h = 1'b0; d = 1'b0;
      if (e < 70) d = 1'b1;
      else if (e < 88) h = 1'b1;
      else if (e < 93) f = 1'b1;
      else begin
        f = 1'($urandom_range(0, 1));
        h = 1'($urandom_range(0, 1));
        d = 1'b1;
      end
      ev(f, h, d, "rnd");
    end

    cmp("excl_strobes", 32'(both_seen), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
